// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the serial sequence detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StArmed = 2'd2
  } state_e;

  localparam logic [7:0] HitMax = 8'd255;

endpackage

// File: rtl/seq_hist_sreg.sv
// History shift register with fill counter; clear-then-accept when clear and enable coincide.
module seq_hist_sreg #(
  parameter int unsigned PAT_W = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic                         flush_i,
  input  logic                         x_i,
  output logic [PAT_W-1:0]             hist_n_o,
  output logic [$clog2(PAT_W+1)-1:0]   fill_n_o,
  output logic [PAT_W-1:0]             hist_o,
  output logic [$clog2(PAT_W+1)-1:0]   fill_o
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d, hist_base;
  logic [FillW-1:0] fill_q, fill_d, fill_base;

  // Candidate history/fill if the current bit were accepted.
  always_comb begin
    hist_base = clr_i ? '0 : hist_q;
    fill_base = clr_i ? '0 : fill_q;
    hist_n_o  = {hist_base[PAT_W-2:0], x_i};
    fill_n_o  = (fill_base == FillMax) ? FillMax : fill_base + FillW'(1);
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (en_i) begin
      hist_d = flush_i ? '0 : hist_n_o;
      fill_d = flush_i ? '0 : fill_n_o;
    end else if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist_o = hist_q;
  assign fill_o = fill_q;

endmodule

// File: rtl/seq_detect_fsm.sv
// Strobed serial pattern detector with registered match flag, sticky found flag and hit counter.
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic                       frame_start_i,
  input  logic                       x_i,
  output logic                       z_o,
  output logic                       z_pulse_o,
  output logic                       found_o,
  output logic [7:0]                 hit_cnt_o,
  output logic [$clog2(PAT_W+1)-1:0] fill_o,
  output logic [1:0]                 state_o
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_W);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] hist_n, hist;
  logic [FillW-1:0] fill_n;
  logic             match, flush;
  logic             z_q, z_d, z_pulse_q, z_pulse_d, found_q, found_d;
  logic [7:0]       hit_cnt_q, hit_cnt_d;

  seq_hist_sreg #(
    .PAT_W (PAT_W)
  ) u_hist (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (frame_start_i),
    .en_i     (en_i),
    .flush_i  (flush),
    .x_i      (x_i),
    .hist_n_o (hist_n),
    .fill_n_o (fill_n),
    .hist_o   (hist),
    .fill_o   (fill_o)
  );

  assign match = en_i && (fill_n == FillMax) && (hist_n == PATTERN);
  assign flush = match && !OVERLAP;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StFill, StArmed: begin
        if (en_i) begin
          if (flush) begin
            state_d = StIdle;
          end else if (fill_n == FillMax) begin
            state_d = StArmed;
          end else begin
            state_d = StFill;
          end
        end else if (frame_start_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // frame_start outranks a same-cycle match for found, but never blocks the count.
  always_comb begin
    z_d       = z_q;
    z_pulse_d = 1'b0;
    found_d   = found_q;
    hit_cnt_d = hit_cnt_q;
    if (en_i) begin
      z_d       = match;
      z_pulse_d = match;
    end else if (frame_start_i) begin
      z_d = 1'b0;
    end
    if (frame_start_i) begin
      found_d = 1'b0;
    end else if (match) begin
      found_d = 1'b1;
    end
    if (match && (hit_cnt_q != HitMax)) begin
      hit_cnt_d = hit_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      z_q       <= 1'b0;
      z_pulse_q <= 1'b0;
      found_q   <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      z_q       <= z_d;
      z_pulse_q <= z_pulse_d;
      found_q   <= found_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign z_o       = z_q;
  assign z_pulse_o = z_pulse_q;
  assign found_o   = found_q;
  assign hit_cnt_o = hit_cnt_q;
  assign state_o   = state_q;

  logic unused_hist;
  assign unused_hist = ^hist;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed bench: three detector variants share one stimulus stream.
module tb_seq_detect_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic frame_start = 1'b0;
  logic x = 1'b0;

  logic       z0, zp0, f0, z1, zp1, f1, z2, zp2, f2;
  logic [7:0] h0, h1, h2;
  logic [2:0] fl0, fl1, fl2;
  logic [1:0] s0, s1, s2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_detect_fsm u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .frame_start_i(frame_start), .x_i(x),
    .z_o(z0), .z_pulse_o(zp0), .found_o(f0), .hit_cnt_o(h0), .fill_o(fl0), .state_o(s0)
  );

  seq_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .frame_start_i(frame_start), .x_i(x),
    .z_o(z1), .z_pulse_o(zp1), .found_o(f1), .hit_cnt_o(h1), .fill_o(fl1), .state_o(s1)
  );

  seq_detect_fsm #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1'b1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .frame_start_i(frame_start), .x_i(x),
    .z_o(z2), .z_pulse_o(zp2), .found_o(f2), .hit_cnt_o(h2), .fill_o(fl2), .state_o(s2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are applied at a negedge and held across one posedge; outputs sampled at next negedge.
  task automatic drive(input logic e, input logic f, input logic b);
    en = e;
    frame_start = f;
    x = b;
    @(negedge clk);
    en = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Test 1: reset values and single 1011 match
    do_reset();
    chk("rst_z", z0, 0);
    chk("rst_zp", zp0, 0);
    chk("rst_found", f0, 0);
    chk("rst_hit", h0, 0);
    chk("rst_fill", fl0, 0);
    chk("rst_state", s0, 0);
    drive(1, 0, 1); chk("t1_z_b1", z0, 0); chk("t1_state_b1", s0, 1);
    drive(1, 0, 0); chk("t1_z_b2", z0, 0);
    drive(1, 0, 1); chk("t1_z_b3", z0, 0); chk("t1_fill_b3", fl0, 3);
    drive(1, 0, 1);
    chk("t1_z_b4", z0, 1);
    chk("t1_zp_b4", zp0, 1);
    chk("t1_hit", h0, 1);
    chk("t1_found", f0, 1);
    chk("t1_state", s0, 2);
    drive(0, 0, 0);
    chk("t1_zp_drop", zp0, 0);
    chk("t1_z_hold", z0, 1);

    // Test 2: overlap vs non-overlap on 1011011
    do_reset();
    drive(1, 0, 1); drive(1, 0, 0); drive(1, 0, 1); drive(1, 0, 1);
    chk("t2_ov_z_b4", z0, 1);
    chk("t2_nov_z_b4", z1, 1);
    chk("t2_nov_fill_b4", fl1, 0);
    chk("t2_nov_state_b4", s1, 0);
    drive(1, 0, 0); chk("t2_ov_z_b5", z0, 0);
    drive(1, 0, 1); chk("t2_ov_z_b6", z0, 0);
    drive(1, 0, 1);
    chk("t2_ov_z_b7", z0, 1);
    chk("t2_ov_hit", h0, 2);
    chk("t2_nov_z_b7", z1, 0);
    chk("t2_nov_fill_b7", fl1, 3);
    chk("t2_nov_hit", h1, 1);

    // Test 3: gapped strobes, then frame_start with en=0
    do_reset();
    drive(1, 0, 1);
    for (int i = 0; i < 5; i++) begin drive(0, 0, 1); chk("t3_gap1_z", z0, 0); end
    drive(1, 0, 0);
    for (int i = 0; i < 5; i++) begin drive(0, 0, 1); chk("t3_gap2_z", z0, 0); end
    drive(1, 0, 1);
    chk("t3_fill3", fl0, 3);
    chk("t3_state_fill", s0, 1);
    drive(0, 1, 0);
    chk("t3_fs_fill", fl0, 0);
    chk("t3_fs_state", s0, 0);
    drive(1, 0, 1);
    chk("t3_z", z0, 0);
    chk("t3_found", f0, 0);
    chk("t3_fill1", fl0, 1);
    chk("t3_state", s0, 1);

    // Test 4: z held through idle cycles, frame_start clears z/found but not count
    do_reset();
    drive(1, 0, 1); drive(1, 0, 0); drive(1, 0, 1); drive(1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0);
      chk("t4_z_hold", z0, 1);
      chk("t4_zp_low", zp0, 0);
    end
    drive(0, 1, 0);
    chk("t4_fs_z", z0, 0);
    chk("t4_fs_found", f0, 0);
    chk("t4_fs_hit", h0, 1);
    drive(1, 1, 1);
    chk("t4_fsen_fill", fl0, 1);
    chk("t4_fsen_state", s0, 1);
    chk("t4_fsen_z", z0, 0);

    // Test 5: saturation on pattern 1111, then asynchronous reset mid-strobe
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      drive(1, 0, 1);
      if (i == 3) chk("t5_hit_b3", h2, 0);
      if (i == 4) chk("t5_hit_b4", h2, 1);
      if (i == 257) chk("t5_hit_b257", h2, 254);
      if (i == 258) chk("t5_hit_b258", h2, 255);
    end
    chk("t5_hit_sat", h2, 255);
    chk("t5_z", z2, 1);
    chk("t5_zp", zp2, 1);
    en = 1'b1;
    x = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_arst_z", z2, 0);
    chk("t5_arst_zp", zp2, 0);
    chk("t5_arst_found", f2, 0);
    chk("t5_arst_hit", h2, 0);
    chk("t5_arst_fill", fl2, 0);
    chk("t5_arst_state", s2, 0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 1);
    chk("t5_post_fill", fl2, 1);
    chk("t5_post_state", s2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
